kbd_scode_dec: RTL and testbench
================================

# kbd_scode_dec

PS/2 scan-code set 2 decoder sitting directly downstream of the keyboard receiver. Consumes the receiver's `scode`/`scode_en` byte stream and `rx_err` status. Folds E0/F0/E1 prefix sequences into single key events, tracks modifier state, and buffers events in a small FIFO with a valid/ready interface toward the host logic.

## Interface
- `DEPTH`, 8: event FIFO depth. Power of two, 2..64.
- `clk`  in  1  system clock, the same domain as the receiver.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scode`  in  8  received byte; valid only while `scode_en` is high.
- `scode_en`  in  1  one-cycle strobe per received byte.
- `rx_err`  in  8  receiver error status; any nonzero bit is an error.
- `ev_code`  out  8  event key code (final byte of the sequence).
- `ev_ext`  out  1  event came from an E0 (or E1) sequence.
- `ev_brk`  out  1  event is a key release (F0 seen).
- `ev_ascii`  out  8  ASCII translation; see Configuration.
- `ev_valid`  out  1  FIFO head is valid.
- `ev_ready`  in  1  consumer accepts the head.
- `mods`  out  4  {alt, ctrl, rshift, lshift}, live key-down state.
- `bat_ok`  out  1  one-cycle pulse on standalone 0xAA.
- `ovf`  out  1  sticky flag: an event was dropped on full FIFO.
- `ovf_clr`  in  1  clears `ovf`.
- `ev_cnt`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- The decoder FSM has states IDLE, E0, F0, E0F0 and PAUSE. A byte is consumed only on a cycle where `scode_en` is high and `rx_err` is zero.
- In IDLE:
  - E0 goes to E0; F0 goes to F0; E1 goes to PAUSE with `pcnt` cleared.
  - AA pulses `bat_ok`. FA, FE, EE, 00 and FF are dropped.
  - Any other byte emits {ext=0, brk=0, code}.
- In E0: F0 goes to E0F0; E0 stays in E0; E1 restarts into PAUSE. Any other byte emits {1,0,code} and goes to IDLE.
- In F0: F0 stays in F0; E0 goes to E0F0. Any other byte emits {0,1,code} and goes to IDLE.
- In E0F0: E0 and F0 keep the state. Any other byte emits {1,1,code} and goes to IDLE.
- In PAUSE: each byte increments the 3-bit `pcnt`. The 7th byte emits {1,0,0x77} and goes to IDLE.
- Error handling: a nonzero `rx_err` in any cycle forces IDLE and clears `pcnt`. A `scode_en` in that same cycle is discarded.
- Emit updates `mods` on the same edge as the FIFO write, independent of FIFO space:
  - 0x12 → lshift; 0x59 → rshift (both non-ext only).
  - 0x14 → ctrl; 0x11 → alt (ext or not).
  - Make sets the bit; break clears it.
- FIFO is first-word-fall-through:
  - Write on emit when not full. Pop when `ev_valid & ev_ready`.
  - Emit while full drops the event and sets `ovf`. Exception: a pop in the same cycle frees the slot, so the write succeeds and nothing is dropped.
  - Push and pop in the same cycle leave `ev_cnt` unchanged.
  - Pointers wrap modulo DEPTH. `ev_cnt` saturates at DEPTH by construction.
- `ovf`: `ovf_clr` clears it. If a drop and `ovf_clr` occur in the same cycle, set wins.

## Timing
- Reset values:
  - FSM IDLE, `pcnt`=0, FIFO empty.
  - `ev_valid`=0, `ev_cnt`=0, `mods`=0, `ovf`=0, `bat_ok`=0.
  - `ev_code`, `ev_ext`, `ev_brk` and `ev_ascii` read 0.
- Latency: a byte completing an event on edge N makes `ev_valid` high after edge N. This is one cycle after the strobe.
- `mods` is visible after the same edge N.
- The head payload is stable while `ev_valid` is high and `ev_ready` is low.
- `bat_ok` is high for exactly the cycle after the 0xAA strobe.
- Back-to-back strobes on consecutive cycles are accepted, one byte per cycle.

## Configuration
- `KBD_DEC_ASCII_EN` defined:
  - The FIFO word widens to 18 bits and carries an ASCII byte computed at emit time. Shift is taken from `mods` before the current event's update.
  - Translation applies to non-ext codes, on make and break. Ext codes give 0x00.
  - Letters a–z map to 0x61–0x7A, or to 0x41–0x5A when lshift|rshift.
  - Digits 0–9 map to 0x30–0x39 regardless of shift.
  - 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09, 0x76→0x1B. All other codes give 0x00.
- `KBD_DEC_ASCII_EN` undefined: the FIFO word is 10 bits, `ev_ascii` is tied to 0x00, and no table is synthesized.

## Test plan
- Byte 0x1C, `ev_ready`=1 → one event {code 0x1C, ext 0, brk 0} one cycle later. With the macro, `ev_ascii`=0x61.
- Bytes 0x12, 0x1C, F0 0x1C, F0 0x12 → events 0x12 make, 0x1C make, 0x1C break, 0x12 break.
  - `mods`=0001 between the first and last events, 0000 after.
  - With the macro, the 0x1C events carry ASCII 0x41.
- Bytes E0 F0 0x75 → {0x75, ext 1, brk 1}. Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {0x77, ext 1, brk 0}.
- Bytes E0, then `rx_err`=0x04 for one cycle, then 0x1C → single event {0x1C, ext 0, brk 0}.
- DEPTH=8, `ev_ready`=0, 9 make bytes:
  - `ev_cnt`=8 and `ovf`=1; the 9th event is lost.
  - `ovf_clr` clears `ovf`.
  - Draining returns the first 8 events in order.
- Full FIFO, emit and pop in the same cycle → `ev_cnt` stays 8 and `ovf` stays 0. Byte 0xAA → `bat_ok` pulse only, no event.

Source files
------------

// File: rtl/kbd_scode_dec.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events, tracks modifiers, FWFT event FIFO.
// Optional ASCII translation column enabled by defining KBD_DEC_ASCII_EN.
module kbd_scode_dec #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               scode,
   input  logic                     scode_en,
   input  logic [7:0]               rx_err,
   output logic [7:0]               ev_code,
   output logic                     ev_ext,
   output logic                     ev_brk,
   output logic [7:0]               ev_ascii,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [3:0]               mods,
   output logic                     bat_ok,
   output logic                     ovf,
   input  logic                     ovf_clr,
   output logic [$clog2(DEPTH):0]   ev_cnt
);
   localparam int AW = $clog2(DEPTH);
`ifdef KBD_DEC_ASCII_EN
   localparam int WW = 18;
`else
   localparam int WW = 10;
`endif

   typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     pcnt_q, pcnt_d;
   logic [3:0]     mods_q, mods_d;
   logic           bat_q, bat_d;
   logic           ovf_q, ovf_d;
   logic [AW-1:0]  wr_q, rd_q;
   logic [AW:0]    cnt_q, cnt_d;
   logic [WW-1:0]  mem [DEPTH];
   logic [WW-1:0]  wr_word, head;
   logic           emit, e_ext, e_brk;
   logic [7:0]     e_code;
   logic           full, push, pop, drop;

`ifdef KBD_DEC_ASCII_EN
   function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh);
      logic [7:0] a;
      logic       letter;
      a = 8'h00;
      letter = 1'b1;
      case (c)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         default: letter = 1'b0;
      endcase
      if (letter && sh) a = a - 8'h20;
      case (c)
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;  8'h0D: a = 8'h09;
         8'h76: a = 8'h1B;
         default: ;
      endcase
      return a;
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      emit    = 1'b0;
      e_ext   = 1'b0;
      e_brk   = 1'b0;
      e_code  = scode;
      bat_d   = 1'b0;
      if (rx_err != 8'h00) begin
         state_d = S_IDLE;
         pcnt_d  = 3'd0;
      end else if (scode_en) begin
         case (state_q)
            S_IDLE: begin
               case (scode)
                  8'hE0: state_d = S_E0;
                  8'hF0: state_d = S_F0;
                  8'hE1: begin state_d = S_PAUSE; pcnt_d = 3'd0; end
                  8'hAA: bat_d = 1'b1;
                  8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                  default: emit = 1'b1;
               endcase
            end
            S_E0: begin
               case (scode)
                  8'hF0: state_d = S_E0F0;
                  8'hE0: state_d = S_E0;
                  8'hE1: begin state_d = S_PAUSE; pcnt_d = 3'd0; end
                  default: begin emit = 1'b1; e_ext = 1'b1; state_d = S_IDLE; end
               endcase
            end
            S_F0: begin
               case (scode)
                  8'hF0: state_d = S_F0;
                  8'hE0: state_d = S_E0F0;
                  default: begin emit = 1'b1; e_brk = 1'b1; state_d = S_IDLE; end
               endcase
            end
            S_E0F0: begin
               if (scode != 8'hE0 && scode != 8'hF0) begin
                  emit    = 1'b1;
                  e_ext   = 1'b1;
                  e_brk   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_PAUSE: begin
               // Pause/Break is an 8-byte make-only sequence: E1 plus seven payload bytes.
               if (pcnt_q == 3'd6) begin
                  emit    = 1'b1;
                  e_ext   = 1'b1;
                  e_code  = 8'h77;
                  pcnt_d  = 3'd0;
                  state_d = S_IDLE;
               end else begin
                  pcnt_d = pcnt_q + 3'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      mods_d = mods_q;
      if (emit) begin
         if (!e_ext && e_code == 8'h12) mods_d[0] = ~e_brk;
         if (!e_ext && e_code == 8'h59) mods_d[1] = ~e_brk;
         if (e_code == 8'h14)           mods_d[2] = ~e_brk;
         if (e_code == 8'h11)           mods_d[3] = ~e_brk;
      end
   end

   assign full = (cnt_q == (AW+1)'(DEPTH));
   assign pop  = (cnt_q != '0) && ev_ready;
   assign push = emit && (!full || pop);
   assign drop = emit && full && !pop;
   assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

`ifdef KBD_DEC_ASCII_EN
   assign wr_word = {(e_ext ? 8'h00 : to_ascii(e_code, mods_q[0] | mods_q[1])), e_ext, e_brk, e_code};
`else
   assign wr_word = {e_ext, e_brk, e_code};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pcnt_q  <= 3'd0;
         mods_q  <= 4'd0;
         bat_q   <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         mods_q  <= mods_d;
         bat_q   <= bat_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= wr_word;
   end

   // Payload is gated so an empty FIFO presents zeros regardless of stale storage.
   assign head     = mem[rd_q];
   assign ev_valid = (cnt_q != '0);
   assign ev_code  = ev_valid ? head[7:0] : 8'h00;
   assign ev_brk   = ev_valid & head[8];
   assign ev_ext   = ev_valid & head[9];
`ifdef KBD_DEC_ASCII_EN
   assign ev_ascii = ev_valid ? head[17:10] : 8'h00;
`else
   assign ev_ascii = 8'h00;
`endif
   assign mods   = mods_q;
   assign bat_ok = bat_q;
   assign ovf    = ovf_q;
   assign ev_cnt = cnt_q;
endmodule

// File: tb/tb_kbd_scode_dec.sv
// Self-checking bench for kbd_scode_dec: directed test-plan sequences plus random byte streams
// compared every cycle against a prefix-flag reference model and an event queue.
module tb_kbd_scode_dec;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] scode = 8'h00;
   logic       scode_en = 1'b0;
   logic [7:0] rx_err = 8'h00;
   logic       ev_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] ev_code, ev_ascii;
   logic       ev_ext, ev_brk, ev_valid, bat_ok, ovf;
   logic [3:0] mods;
   logic [$clog2(DEPTH):0] ev_cnt;

   kbd_scode_dec #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .scode(scode), .scode_en(scode_en), .rx_err(rx_err),
      .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk), .ev_ascii(ev_ascii),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .mods(mods), .bat_ok(bat_ok),
      .ovf(ovf), .ovf_clr(ovf_clr), .ev_cnt(ev_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [7:0] asc;
   } ev_t;

   localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
      8'h3E, 8'h46};

   ev_t        q[$];
   logic       m_ext, m_brk, m_pause, m_ovf, m_bat;
   int         m_pc;
   logic [3:0] m_mods;
   int         n_tests = 0;
   int         n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic ext, input logic sh);
      if (ext) return 8'h00;
      for (int i = 0; i < 26; i++)
         if (c == LETTERS[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (c == DIGITS[i]) return 8'h30 + 8'(i);
      case (c)
         8'h29: return 8'h20;
         8'h5A: return 8'h0D;
         8'h66: return 8'h08;
         8'h0D: return 8'h09;
         8'h76: return 8'h1B;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model(input logic [7:0] sc, input logic en, input logic [7:0] err,
                        input logic rdy, input logic clr);
      logic emit;
      logic drop;
      ev_t  e;
      emit = 1'b0;
      drop = 1'b0;
      e.code = sc; e.ext = 1'b0; e.brk = 1'b0; e.asc = 8'h00;
      m_bat = 1'b0;
      if (err != 8'h00) begin
         m_ext = 1'b0; m_brk = 1'b0; m_pause = 1'b0; m_pc = 0;
      end else if (en) begin
         if (m_pause) begin
            m_pc++;
            if (m_pc == 7) begin
               emit = 1'b1; e.code = 8'h77; e.ext = 1'b1;
               m_pause = 1'b0; m_pc = 0;
            end
         end else if (sc == 8'hE1 && !m_brk) begin
            m_pause = 1'b1; m_pc = 0; m_ext = 1'b0;
         end else if (sc == 8'hE0) begin
            m_ext = 1'b1;
         end else if (sc == 8'hF0) begin
            m_brk = 1'b1;
         end else if (!m_ext && !m_brk && sc == 8'hAA) begin
            m_bat = 1'b1;
         end else if (!m_ext && !m_brk && (sc == 8'hFA || sc == 8'hFE || sc == 8'hEE ||
                                           sc == 8'h00 || sc == 8'hFF)) begin
         end else begin
            emit = 1'b1; e.ext = m_ext; e.brk = m_brk;
            m_ext = 1'b0; m_brk = 1'b0;
         end
      end
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (emit) begin
`ifdef KBD_DEC_ASCII_EN
         e.asc = ref_ascii(e.code, e.ext, m_mods[0] | m_mods[1]);
`endif
         if (!e.ext && e.code == 8'h12) m_mods[0] = !e.brk;
         if (!e.ext && e.code == 8'h59) m_mods[1] = !e.brk;
         if (e.code == 8'h14) m_mods[2] = !e.brk;
         if (e.code == 8'h11) m_mods[3] = !e.brk;
         if (q.size() < DEPTH) q.push_back(e);
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   task automatic check_all();
      logic [17:0] exp_head;
      exp_head = (q.size() > 0) ? {q[0].asc, q[0].ext, q[0].brk, q[0].code} : 18'h0;
      chk("valid", 32'(ev_valid), 32'(q.size() > 0));
      chk("cnt", 32'(ev_cnt), 32'(q.size()));
      chk("mods", 32'(mods), 32'(m_mods));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("bat_ok", 32'(bat_ok), 32'(m_bat));
      chk("head", 32'({ev_ascii, ev_ext, ev_brk, ev_code}), 32'(exp_head));
   endtask

   task automatic cyc(input logic [7:0] sc, input logic en, input logic [7:0] err,
                      input logic rdy, input logic clr);
      scode = sc; scode_en = en; rx_err = err; ev_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      #1;
      model(sc, en, err, rdy, clr);
      check_all();
      scode_en = 1'b0; rx_err = 8'h00; ovf_clr = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic rdy);
      cyc(b, 1'b1, 8'h00, rdy, 1'b0);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 8'h00, rdy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq_pause [8];
      logic [7:0] makes [9];
      logic       rdy_ph;
      logic [7:0] b;
      int         r;
      seq_pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      makes     = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
      m_ext = 0; m_brk = 0; m_pause = 0; m_pc = 0; m_mods = 0; m_ovf = 0; m_bat = 0;

      repeat (3) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;

      send(8'h1C, 1'b1);
      chk("single_code", 32'(ev_code), 32'h1C);
      idle(1, 1'b1);

      send(8'h12, 1'b1);
      send(8'h1C, 1'b1);
      chk("shift_held", 32'(mods), 32'h1);
      send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h12, 1'b1);
      chk("shift_released", 32'(mods), 32'h0);
      idle(2, 1'b1);

      send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
      chk("e0f0_flags", 32'({ev_ext, ev_brk, ev_code}), 32'h375);
      idle(1, 1'b1);
      for (int i = 0; i < 8; i++) send(seq_pause[i], 1'b0);
      chk("pause_one_event", 32'(ev_cnt), 32'd1);
      chk("pause_code", 32'({ev_ext, ev_brk, ev_code}), 32'h277);
      idle(2, 1'b1);

      send(8'hE0, 1'b0);
      cyc(8'h00, 1'b0, 8'h04, 1'b0, 1'b0);
      send(8'h1C, 1'b0);
      chk("err_abort", 32'({ev_ext, ev_brk, ev_code}), 32'h01C);
      idle(2, 1'b1);

      for (int i = 0; i < 9; i++) send(makes[i], 1'b0);
      chk("full_cnt", 32'(ev_cnt), 32'd8);
      chk("full_ovf", 32'(ovf), 32'd1);
      cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", 32'(ovf), 32'd0);
      send(8'h4D, 1'b1);
      chk("push_pop_full_cnt", 32'(ev_cnt), 32'd8);
      chk("push_pop_full_ovf", 32'(ovf), 32'd0);
      send(8'hAA, 1'b0);
      chk("bat_pulse", 32'(bat_ok), 32'd1);
      idle(1, 1'b0);
      chk("bat_one_cycle", 32'(bat_ok), 32'd0);
      idle(10, 1'b1);

      rdy_ph = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 39) == 0) rdy_ph = ~rdy_ph;
         r = $urandom_range(0, 15);
         case (r)
            0: b = 8'hE0;
            1: b = 8'hF0;
            2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'hF0;
            3: b = 8'hAA;
            4: b = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'h00;
            5: b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            6: b = ($urandom_range(0, 1) == 0) ? 8'h14 : 8'h11;
            7, 8, 9: b = LETTERS[$urandom_range(0, 25)];
            10: b = DIGITS[$urandom_range(0, 9)];
            default: b = 8'($urandom_range(0, 255));
         endcase
         cyc(b, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 29) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
             rdy_ph ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0),
             $urandom_range(0, 24) == 0);
      end
      idle(12, 1'b1);
      chk("final_drain", 32'(ev_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
